// File: rtl/dclk_cfg_ctrl.sv
// dclk_cfg_ctrl: sequences a glitch-free reconfiguration of the clock divider and
// measures the resulting dclk period.
//   clk_i      system clock (dclk_i is derived from it and sampled as data)
//   rstn_i     async active-low reset
//   cfg_req_i  request, held high until cfg_ack_o
//   cfg_sel_i  requested divider select (latched on accept)
//   cfg_en_i   1 = run divider at cfg_sel_i, 0 = stop divider
//   cfg_ack_o  one-cycle completion pulse
//   cfg_ok_o   result, valid with ack, held until next ack
//   busy_o     high whenever a request is in progress
//   meas_o     last measured dclk period in clk cycles
//   sel_o      divider select
//   en_o       divider enable
//   dclk_i     divided clock from the divider
module dclk_cfg_ctrl #(
    parameter int         CNT_W    = 10,
    parameter int         GATE_CYC = 4,
    parameter int         TIMEOUT  = 1023,
    parameter logic [1:0] RST_SEL  = 2'b00
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             cfg_req_i,
    input  logic [1:0]       cfg_sel_i,
    input  logic             cfg_en_i,
    output logic             cfg_ack_o,
    output logic             cfg_ok_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] meas_o,
    output logic [1:0]       sel_o,
    output logic             en_o,
    input  logic             dclk_i
);
    typedef enum logic [2:0] {IDLE, WLOW, GATE, APPLY, SYNC, MEAS, FAIL, DONE} state_t;
    localparam logic [CNT_W-1:0] TOUT      = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYC - 1);
    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] exp_p;
    logic [1:0]       sel_l;
    logic             en_l;
    logic             armed;
    logic             dclk_q;
    logic             rise;
    assign rise   = dclk_i & ~dclk_q;
    // expected period 2^(7-sel): 128, 64, 32, 16
    assign exp_p  = CNT_W'(128) >> sel_o;
    assign busy_o = state != IDLE;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            timer     <= '0;
            cnt       <= '0;
            sel_l     <= RST_SEL;
            en_l      <= 1'b0;
            armed     <= 1'b1;
            dclk_q    <= 1'b0;
            cfg_ack_o <= 1'b0;
            cfg_ok_o  <= 1'b0;
            meas_o    <= '0;
            sel_o     <= RST_SEL;
            en_o      <= 1'b0;
        end else begin
            dclk_q    <= dclk_i;
            cfg_ack_o <= 1'b0;
            timer     <= timer + 1'b1;
            case (state)
                IDLE: if (cfg_req_i && armed) begin
                    sel_l <= cfg_sel_i;
                    en_l  <= cfg_en_i;
                    timer <= '0;
                    state <= en_o ? WLOW : GATE;
                end
                // stop the divider only while dclk is low so no runt pulse escapes
                WLOW: if (!dclk_i) begin
                    en_o  <= 1'b0;
                    timer <= '0;
                    state <= GATE;
                end else if (timer == TOUT) begin
                    timer <= '0;
                    state <= FAIL;
                end
                GATE: if (timer == GATE_LAST) begin
                    timer <= '0;
                    if (en_l) begin
                        state <= APPLY;
                    end else begin
                        cfg_ack_o <= 1'b1;
                        cfg_ok_o  <= 1'b1;
                        armed     <= 1'b0;
                        state     <= DONE;
                    end
                end
                APPLY: begin
                    sel_o <= sel_l;
                    en_o  <= 1'b1;
                    timer <= '0;
                    state <= SYNC;
                end
                SYNC: if (rise) begin
                    cnt   <= CNT_W'(1);
                    timer <= '0;
                    state <= MEAS;
                end else if (timer == TOUT) begin
                    timer <= '0;
                    state <= FAIL;
                end
                MEAS: if (rise) begin
                    meas_o    <= cnt;
                    cfg_ack_o <= 1'b1;
                    cfg_ok_o  <= cnt == exp_p;
                    armed     <= 1'b0;
                    state     <= DONE;
                end else if (timer == TOUT) begin
                    timer <= '0;
                    state <= FAIL;
                end else begin
                    cnt <= &cnt ? cnt : cnt + 1'b1;
                end
                FAIL: begin
                    en_o      <= 1'b0;
                    meas_o    <= '0;
                    cfg_ack_o <= 1'b1;
                    cfg_ok_o  <= 1'b0;
                    armed     <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    timer <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // a held request never retriggers; dropping it re-arms
            if (!cfg_req_i) armed <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dclk_cfg_ctrl.sv
// tb_dclk_cfg_ctrl: randomized bench for dclk_cfg_ctrl with a behavioural divider.
module tb_dclk_cfg_ctrl;
    localparam int CNT_W    = 10;
    localparam int GATE_CYC = 4;
    localparam int TIMEOUT  = 1023;
    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             req = 1'b0;
    logic [1:0]       sel_in = 2'b00;
    logic             en_in = 1'b0;
    logic             ack, ok, busy, en, dclk;
    logic [CNT_W-1:0] meas;
    logic [1:0]       sel;
    int passed = 0, total = 0;
    bit stuck = 0;
    int ack_cnt = 0, sel_bad = 0, low_run = 0, min_gate = 100000;
    int dcnt = 0, run = 0, min_pulse = 100000;
    logic en_prev = 1'b0;
    logic [1:0] sel_prev = 2'b00;
    logic [1:0]       m_sel;
    logic             m_en;
    logic [CNT_W-1:0] m_meas;
    dclk_cfg_ctrl #(.CNT_W(CNT_W), .GATE_CYC(GATE_CYC), .TIMEOUT(TIMEOUT), .RST_SEL(2'b00)) dut (
        .clk_i(clk), .rstn_i(rstn), .cfg_req_i(req), .cfg_sel_i(sel_in), .cfg_en_i(en_in),
        .cfg_ack_o(ack), .cfg_ok_o(ok), .busy_o(busy), .meas_o(meas), .sel_o(sel),
        .en_o(en), .dclk_i(dclk)
    );
    always #5 clk = ~clk;
    // divider model plus monitors, all evaluated on the falling edge
    initial begin
        dclk = 1'b0;
        forever begin
            @(negedge clk);
            if (ack === 1'b1) ack_cnt++;
            if (en_prev && sel !== sel_prev) sel_bad++;
            if (!en) low_run++;
            else if (!en_prev) begin
                if (low_run < min_gate) min_gate = low_run;
                low_run = 0;
            end
            if (!en || stuck) begin
                dclk = 1'b0;
                dcnt = 0;
                run = 0;
            end else begin
                dcnt++;
                run++;
                if (dcnt >= (64 >> sel)) begin
                    dclk = ~dclk;
                    dcnt = 0;
                    if (run < min_pulse) min_pulse = run;
                    run = 0;
                end
            end
            en_prev = en;
            sel_prev = sel;
        end
    end
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
    task automatic run_req(input logic [1:0] s, input logic e, input bit scramble, output bit got, output int lat);
        got = 0;
        lat = 0;
        req = 1'b1;
        sel_in = s;
        en_in = e;
        while (!got && lat < 3000) begin
            @(negedge clk);
            lat++;
            if (scramble && lat == 2) begin
                sel_in = 2'($urandom);
                en_in = 1'($urandom);
            end
            if (ack === 1'b1) got = 1;
        end
        total++;
        if (!got) $display("FAIL ack_timeout: no ack after %0d cycles", lat);
        else passed++;
    endtask
    task automatic drop_req();
        req = 1'b0;
        repeat (3) @(negedge clk);
    endtask
    task automatic test_reset();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #100;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        m_sel = 2'b00; m_en = 1'b0; m_meas = '0;
        total++; if (sel !== 2'b00) $display("FAIL reset_sel: got %b want 00", sel); else passed++;
        total++; if (en !== 1'b0) $display("FAIL reset_en: got %b want 0", en); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (ack !== 1'b0 || ack_cnt != 0) $display("FAIL reset_ack: got %b/%0d want 0/0", ack, ack_cnt); else passed++;
        total++; if (ok !== 1'b0) $display("FAIL reset_ok: got %b want 0", ok); else passed++;
        total++; if (meas !== '0) $display("FAIL reset_meas: got %0d want 0", meas); else passed++;
    endtask
    task automatic test_enable();
        bit got;
        int lat;
        min_gate = 100000;
        run_req(2'd0, 1'b1, 0, got, lat);
        total++; if (ok !== 1'b1) $display("FAIL enable_ok: got %b want 1", ok); else passed++;
        total++; if (meas !== CNT_W'(128)) $display("FAIL enable_meas: got %0d want 128", meas); else passed++;
        total++; if (en !== 1'b1 || sel !== 2'd0) $display("FAIL enable_out: got en=%b sel=%0d want en=1 sel=0", en, sel); else passed++;
        total++; if (lat != 1 + GATE_CYC + 1 + 64 + 128) $display("FAIL enable_latency: got %0d want %0d", lat, 1 + GATE_CYC + 1 + 64 + 128); else passed++;
        total++; if (min_gate < GATE_CYC) $display("FAIL enable_gate: en low %0d cycles want >= %0d", min_gate, GATE_CYC); else passed++;
        m_sel = 2'd0; m_en = 1'b1; m_meas = CNT_W'(128);
        drop_req();
    endtask
    task automatic test_switch();
        bit got;
        int lat;
        min_gate = 100000;
        min_pulse = 100000;
        sel_bad = 0;
        run_req(2'd3, 1'b1, 1, got, lat);
        total++; if (ok !== 1'b1 || meas !== CNT_W'(16)) $display("FAIL switch_result: got ok=%b meas=%0d want ok=1 meas=16", ok, meas); else passed++;
        total++; if (sel !== 2'd3 || en !== 1'b1) $display("FAIL switch_out: got sel=%0d en=%b want sel=3 en=1", sel, en); else passed++;
        total++; if (sel_bad != 0) $display("FAIL switch_glitch: sel changed %0d times while enabled want 0", sel_bad); else passed++;
        total++; if (min_gate < GATE_CYC) $display("FAIL switch_gate: en low %0d cycles want >= %0d", min_gate, GATE_CYC); else passed++;
        total++; if (min_pulse < 8) $display("FAIL switch_pulse: shortest dclk pulse %0d want >= 8", min_pulse); else passed++;
        m_sel = 2'd3; m_en = 1'b1; m_meas = CNT_W'(16);
        drop_req();
    endtask
    task automatic test_timeout();
        bit got;
        int lat;
        logic [1:0] s;
        s = 2'($urandom);
        stuck = 1;
        run_req(s, 1'b1, 0, got, lat);
        total++; if (ok !== 1'b0 || en !== 1'b0 || meas !== '0) $display("FAIL timeout_result: got ok=%b en=%b meas=%0d want 0/0/0", ok, en, meas); else passed++;
        total++; if (lat < TIMEOUT || lat > TIMEOUT + GATE_CYC + 80) $display("FAIL timeout_latency: got %0d want %0d..%0d", lat, TIMEOUT, TIMEOUT + GATE_CYC + 80); else passed++;
        stuck = 0;
        m_sel = s; m_en = 1'b0; m_meas = '0;
        drop_req();
    endtask
    task automatic test_held_req();
        bit got;
        int lat, a0;
        logic [1:0] s;
        s = 2'($urandom);
        run_req(s, 1'b1, 0, got, lat);
        total++; if (ok !== 1'b1 || meas !== CNT_W'(128 >> s)) $display("FAIL held_first: got ok=%b meas=%0d want 1/%0d", ok, meas, 128 >> s); else passed++;
        m_sel = s; m_en = 1'b1; m_meas = CNT_W'(128 >> s);
        @(negedge clk);
        a0 = ack_cnt;
        repeat (500) @(negedge clk);
        total++; if (ack_cnt != a0 || busy !== 1'b0) $display("FAIL held_retrigger: extra acks %0d busy=%b want 0/0", ack_cnt - a0, busy); else passed++;
        req = 1'b0;
        @(negedge clk);
        run_req(2'($urandom), 1'b0, 0, got, lat);
        total++; if (ok !== 1'b1 || en !== 1'b0) $display("FAIL held_stop: got ok=%b en=%b want 1/0", ok, en); else passed++;
        total++; if (sel !== m_sel || meas !== m_meas) $display("FAIL held_stop_keep: got sel=%0d meas=%0d want %0d/%0d", sel, meas, m_sel, m_meas); else passed++;
        m_en = 1'b0;
        drop_req();
    endtask
    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            bit got;
            int lat, lo, hi;
            logic [1:0] s;
            logic e;
            logic [1:0]       x_sel;
            logic             x_en;
            logic [CNT_W-1:0] x_meas;
            s = 2'($urandom);
            e = $urandom_range(0, 3) != 0;
            x_sel = e ? s : m_sel;
            x_en = e;
            x_meas = e ? CNT_W'(128 >> s) : m_meas;
            lo = e ? 1 + GATE_CYC + 1 + (64 >> s) + (128 >> s) : 1 + GATE_CYC;
            hi = lo + 2 + (m_en ? (64 >> m_sel) + 2 : 0);
            sel_bad = 0;
            run_req(s, e, 1, got, lat);
            total++;
            if (ok !== 1'b1 || sel !== x_sel || en !== x_en || meas !== x_meas)
                $display("FAIL random_%0d: got ok=%b sel=%0d en=%b meas=%0d want 1/%0d/%b/%0d", i, ok, sel, en, meas, x_sel, x_en, x_meas);
            else passed++;
            total++;
            if (lat < lo || lat > hi || sel_bad != 0)
                $display("FAIL random_timing_%0d: got lat=%0d glitches=%0d want %0d..%0d/0", i, lat, sel_bad, lo, hi);
            else passed++;
            m_sel = x_sel; m_en = x_en; m_meas = x_meas;
            drop_req();
        end
    endtask
    task automatic test_reset_mid();
        int a0, w;
        logic [1:0] s;
        s = 2'($urandom);
        req = 1'b1;
        sel_in = s;
        en_in = 1'b1;
        w = 0;
        while (en !== 1'b1 && w < 500) begin
            @(negedge clk);
            w++;
        end
        total++; if (en !== 1'b1) $display("FAIL midreset_enable: en=%b after %0d cycles want 1", en, w); else passed++;
        repeat ((64 >> s) + 5) @(negedge clk);
        a0 = ack_cnt;
        rstn = 1'b0;
        #1;
        total++;
        if (sel !== 2'b00 || en !== 1'b0 || busy !== 1'b0 || ack !== 1'b0 || ok !== 1'b0 || meas !== '0)
            $display("FAIL midreset_outputs: got sel=%0d en=%b busy=%b ack=%b ok=%b meas=%0d want all 0", sel, en, busy, ack, ok, meas);
        else passed++;
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        req = 1'b0;
        repeat (300) @(negedge clk);
        total++; if (ack_cnt != a0 || busy !== 1'b0 || en !== 1'b0) $display("FAIL midreset_noack: acks %0d busy=%b en=%b want 0/0/0", ack_cnt - a0, busy, en); else passed++;
    endtask
    initial begin
        test_reset();
        test_enable();
        test_switch();
        test_timeout();
        test_held_req();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
